// File: rtl/wall_slice_calculator.sv
// Per-ray wall slice stage: divides the projection constant by the hit distance,
// clamps the height to the screen and presents vertical draw bounds behind a
// valid/ready handshake.
module wall_slice_calculator #(
    parameter int unsigned DIST_W       = 12,
    parameter int unsigned SCALE_W      = 16,
    parameter int unsigned HEIGHT_SCALE = 30720,
    parameter int unsigned H_W          = 10,
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned COL_W        = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIST_W-1:0] in_distance_x,
    input  logic [DIST_W-1:0] in_distance_y,
    input  logic              in_side,
    input  logic              in_is_wall,
    input  logic [COL_W-1:0]  in_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [H_W-1:0]    out_height,
    output logic [H_W-1:0]    out_draw_start,
    output logic [H_W-1:0]    out_draw_end,
    output logic              out_empty,
    output logic              out_side,
    output logic [COL_W-1:0]  out_col,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(SCALE_W + 1);
    localparam int unsigned REM_W = SCALE_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FINISH = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [DIST_W-1:0]  d_reg;
    logic               side_reg;
    logic               wall_reg;
    logic [COL_W-1:0]   col_reg;
    logic               settle;
    logic [CNT_W-1:0]   count;
    logic [REM_W-1:0]   rem;
    logic [SCALE_W-1:0] quo;

    logic [DIST_W-1:0]  d_in_c;
    logic               accept_c;
    logic               do_divide_c;
    logic [REM_W-1:0]   divisor_c;
    logic [REM_W-1:0]   rem_shift_c;
    logic [REM_W-1:0]   rem_sub_c;
    logic               qbit_c;
    logic [H_W-1:0]     h_c;
    logic [H_W-1:0]     start_c;
    logic [H_W-1:0]     end_c;
    logic               empty_c;

    assign d_in_c      = in_side ? in_distance_y : in_distance_x;
    assign accept_c    = in_valid && (state == IDLE) && frame_en;
    assign do_divide_c = in_is_wall && (d_in_c != '0);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign divisor_c   = REM_W'(d_reg);
    assign rem_shift_c = {rem[REM_W-2:0], quo[SCALE_W-1]};
    assign qbit_c      = (rem_shift_c >= divisor_c);
    assign rem_sub_c   = rem_shift_c - divisor_c;

    // Clamp the quotient to the screen and derive centred draw bounds.
    always_comb begin
        h_c     = '0;
        start_c = '0;
        end_c   = '0;
        empty_c = 1'b0;
        if (!wall_reg) begin
            h_c = '0;
        end else if (d_reg == '0) begin
            h_c = H_W'(SCREEN_H);
        end else if (quo > SCALE_W'(SCREEN_H)) begin
            h_c = H_W'(SCREEN_H);
        end else begin
            h_c = H_W'(quo);
        end
        if (h_c == '0) begin
            start_c = H_W'(SCREEN_H / 2);
            end_c   = H_W'(SCREEN_H / 2 - 1);
            empty_c = 1'b1;
        end else begin
            start_c = (H_W'(SCREEN_H) - h_c) >> 1;
            end_c   = start_c + h_c - H_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = do_divide_c ? DIVIDE : FINISH;
            DIVIDE:  if (count == CNT_W'(SCALE_W - 1)) state_next = FINISH;
            FINISH:  if (!settle) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ray latch and divider; bypassed rays take one settle cycle in FINISH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg    <= '0;
            side_reg <= 1'b0;
            wall_reg <= 1'b0;
            col_reg  <= '0;
            settle   <= 1'b0;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
        end else begin
            if (accept_c) begin
                d_reg    <= d_in_c;
                side_reg <= in_side;
                wall_reg <= in_is_wall;
                col_reg  <= in_col;
                settle   <= !do_divide_c;
                count    <= '0;
                rem      <= '0;
                quo      <= SCALE_W'(HEIGHT_SCALE);
            end
            if (state == DIVIDE) begin
                rem   <= qbit_c ? rem_sub_c : rem_shift_c;
                quo   <= {quo[SCALE_W-2:0], qbit_c};
                count <= count + CNT_W'(1);
            end
            if (state == FINISH) begin
                settle <= 1'b0;
            end
        end
    end

    // Registered handshake flags and result payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready       <= 1'b1;
            busy           <= 1'b0;
            out_valid      <= 1'b0;
            out_height     <= '0;
            out_draw_start <= '0;
            out_draw_end   <= '0;
            out_empty      <= 1'b0;
            out_side       <= 1'b0;
            out_col        <= '0;
        end else begin
            in_ready  <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            out_valid <= (state_next == HOLD);
            if ((state == FINISH) && !settle) begin
                out_height     <= h_c;
                out_draw_start <= start_c;
                out_draw_end   <= end_c;
                out_empty      <= empty_c;
                out_side       <= side_reg;
                out_col        <= col_reg;
            end
        end
    end

endmodule
